// File: rtl/rom_ddr_loader_pkg.sv
// Shared types and constants for the ROM-to-DDR2 preload engine.
package rom_ddr_loader_pkg;

  // Width of a DDR2 byte address on the cache-side memory port.
  localparam int DDR_AW = 28;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROM_RD  = 3'd1,
    ROM_CAP = 3'd2,
    WR_REQ  = 3'd3,
    RD_REQ  = 3'd4,
    CMP     = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Width of one memory-word slot that receives a single ROM lane.
  function automatic int slot_width(int mem_dw, int rom_dw, int lane_w);
    return mem_dw / (rom_dw / lane_w);
  endfunction

endpackage

// File: rtl/rom_ddr_loader_lane_expander.sv
// Spreads the LANE_W-wide lanes of a ROM word into SLOT_W-wide slots of a
// memory word, zero-extending each lane. Lane 0 lands in the LSBs.
module rom_ddr_loader_lane_expander
  import rom_ddr_loader_pkg::*;
#(
  parameter int ROM_DW = 64,
  parameter int LANE_W = 8,
  parameter int MEM_DW = 256
) (
  input  logic [ROM_DW-1:0] lanes_in,
  output logic [MEM_DW-1:0] word_out
);

  localparam int LANES  = ROM_DW / LANE_W;
  localparam int SLOT_W = slot_width(MEM_DW, ROM_DW, LANE_W);

  // Place each lane at the bottom of its slot; upper slot bits stay zero.
  always_comb begin
    word_out = '0;
    for (int i = 0; i < LANES; i++) begin
      word_out[i*SLOT_W +: SLOT_W] = SLOT_W'(lanes_in[i*LANE_W +: LANE_W]);
    end
  end

endmodule

// File: rtl/rom_ddr_loader.sv
// ROM-to-DDR2 preload engine: walks NUM_WORDS ROM words, writes each one
// (lane-expanded) to DDR2 over a valid/ready port and, when VERIFY is set,
// reads it back and counts mismatches.
module rom_ddr_loader
  import rom_ddr_loader_pkg::*;
#(
  parameter int               ROM_DW    = 64,
  parameter int               ROM_AW    = 16,
  parameter int               LANE_W    = 8,
  parameter int               MEM_DW    = 256,
  parameter int               NUM_WORDS = 38400,
  parameter logic [DDR_AW-1:0] BASE_ADDR = 28'h3000000,
  parameter int               ADDR_STEP = 8,
  parameter bit               VERIFY    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic              mismatch,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_data,
  output logic [MEM_DW-1:0] mem_data_wr1,
  input  logic [MEM_DW-1:0] mem_data_rd1,
  output logic [DDR_AW-1:0] mem_data_addr1,
  output logic              mem_rw_data1,
  output logic              mem_valid_data1,
  input  logic              mem_ready_data1
);

  localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(NUM_WORDS - 1);
  localparam logic [DDR_AW-1:0] STEP     = DDR_AW'(ADDR_STEP);

  state_t              state_q, state_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [MEM_DW-1:0]   wdata_q, wdata_d;
  logic [MEM_DW-1:0]   rdata_q, rdata_d;
  logic [DDR_AW-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic                valid_q, valid_d;
  logic                advance;
  logic [MEM_DW-1:0]   expanded;

  rom_ddr_loader_lane_expander #(
    .ROM_DW (ROM_DW),
    .LANE_W (LANE_W),
    .MEM_DW (MEM_DW)
  ) u_expander (
    .lanes_in (rom_data),
    .word_out (expanded)
  );

  // Next-state, handshake and counter logic for the load/verify sequence.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_cnt_d  = err_cnt_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    valid_d    = valid_q;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ROM_RD;
          rom_addr_d = '0;
          err_cnt_d  = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          addr_d     = BASE_ADDR;
          rw_d       = 1'b1;
        end
      end
      // The ROM needs one full cycle with a stable address.
      ROM_RD: state_d = ROM_CAP;
      ROM_CAP: begin
        wdata_d = expanded;
        rw_d    = 1'b1;
        valid_d = 1'b1;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (mem_ready_data1) begin
          if (VERIFY) begin
            // Same address, same held data: just turn the command into a read.
            rw_d    = 1'b0;
            state_d = RD_REQ;
          end else begin
            valid_d = 1'b0;
            advance = 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (mem_ready_data1) begin
          rdata_d = mem_data_rd1;
          valid_d = 1'b0;
          state_d = CMP;
        end
      end
      CMP: begin
        if ((rdata_q != wdata_q) && (err_cnt_q != 16'hFFFF)) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
        advance = 1'b1;
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        rw_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Finishing a word: step the DDR2 address (wraps at 2^28) and either
    // move to the next ROM word or stop without running past the last one.
    if (advance) begin
      addr_d = addr_q + STEP;
      rw_d   = 1'b1;
      if (rom_addr_q == LAST_IDX) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = ROM_RD;
      end
    end
  end

  // Control and output registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      wdata_q    <= '0;
      addr_q     <= BASE_ADDR;
      rw_q       <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      valid_q    <= valid_d;
    end
  end

  // Read-back capture register; only meaningful in CMP, so it needs no reset.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err_cnt         = err_cnt_q;
  assign rom_addr        = rom_addr_q;
  assign mem_data_wr1    = wdata_q;
  assign mem_data_addr1  = addr_q;
  assign mem_rw_data1    = rw_q;
  assign mem_valid_data1 = valid_q;
  assign mismatch        = (state_q == CMP) && (rdata_q != wdata_q);

endmodule

// File: tb/tb_rom_ddr_loader.sv
// Scoreboarded bench for rom_ddr_loader: three instances (write-only,
// verify, address wrap) driven by a ROM model and a randomly stalling
// memory responder; a monitor compares every accepted command.
module tb_rom_ddr_loader;

  localparam int NI = 3;

  typedef struct packed {
    logic         rw;
    logic [27:0]  a;
    logic [255:0] d;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst [NI];
  logic         start [NI];
  logic         busy [NI];
  logic         done [NI];
  logic         mismatch [NI];
  logic         rw [NI];
  logic         valid [NI];
  logic         ready [NI];
  logic [15:0]  err_cnt [NI];
  logic [15:0]  rom_addr [NI];
  logic [63:0]  rom_data [NI];
  logic [63:0]  rom_base [NI];
  logic [255:0] wr [NI];
  logic [255:0] rd [NI];
  logic [27:0]  addr [NI];

  int   errors = 0;
  int   checks = 0;
  cmd_t exp_q [NI][$];
  logic [255:0] wlog [NI][$];
  logic [27:0]  alog [NI][$];
  logic [255:0] mem [logic [31:0]];
  int   mode [NI];
  bit   spur [NI];
  int   corrupt [NI];
  int   rd_base [NI];
  int   rdcnt [NI];
  int   mmcnt [NI];
  int   clr_cnt [NI];

  rom_ddr_loader #(.VERIFY(1'b0), .NUM_WORDS(4), .BASE_ADDR(28'h3000000), .ADDR_STEP(8)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .err_cnt(err_cnt[0]), .mismatch(mismatch[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .mem_data_wr1(wr[0]), .mem_data_rd1(rd[0]), .mem_data_addr1(addr[0]), .mem_rw_data1(rw[0]),
    .mem_valid_data1(valid[0]), .mem_ready_data1(ready[0]));

  rom_ddr_loader #(.VERIFY(1'b1), .NUM_WORDS(4), .BASE_ADDR(28'h3000000), .ADDR_STEP(8)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .err_cnt(err_cnt[1]), .mismatch(mismatch[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .mem_data_wr1(wr[1]), .mem_data_rd1(rd[1]), .mem_data_addr1(addr[1]), .mem_rw_data1(rw[1]),
    .mem_valid_data1(valid[1]), .mem_ready_data1(ready[1]));

  rom_ddr_loader #(.VERIFY(1'b0), .NUM_WORDS(2), .BASE_ADDR(28'hFFFFFF8), .ADDR_STEP(8)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .err_cnt(err_cnt[2]), .mismatch(mismatch[2]), .rom_addr(rom_addr[2]), .rom_data(rom_data[2]),
    .mem_data_wr1(wr[2]), .mem_data_rd1(rd[2]), .mem_data_addr1(addr[2]), .mem_rw_data1(rw[2]),
    .mem_valid_data1(valid[2]), .mem_ready_data1(ready[2]));

  function automatic int num_of(int g);
    return (g == 2) ? 2 : 4;
  endfunction

  function automatic logic [27:0] base_of(int g);
    return (g == 2) ? 28'hFFFFFF8 : 28'h3000000;
  endfunction

  function automatic bit verify_of(int g);
    return (g == 1);
  endfunction

  // Reference lane expansion: byte i of the ROM word becomes 32-bit slot i.
  function automatic logic [255:0] expand(logic [63:0] w);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = {24'd0, w[i*8 +: 8]};
    return r;
  endfunction

  function automatic int new_delay(int m);
    if (m == 0) return 1;
    if (m == 1) return int'($urandom_range(0, 7));
    return 0;
  endfunction

  task automatic chk(string name, int g, logic [255:0] act, logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", name, g, act, req);
    end
  endtask

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) rom_data[g] <= rom_base[g] + 64'(rom_addr[g]);
  end

  // Memory responder and monitor, evaluated mid-cycle on the falling edge.
  initial begin : monitor
    bit          hs_prev [NI];
    bit          prev_v [NI];
    bit          prev_hs [NI];
    logic [27:0] prev_a [NI];
    logic [255:0] prev_d [NI];
    logic        prev_rw [NI];
    int          wait_c [NI];
    int          clr_seen [NI];
    logic [31:0] key;
    cmd_t        e;
    bit          hs;
    for (int g = 0; g < NI; g++) begin
      ready[g] = 1'b0; rd[g] = '0; hs_prev[g] = 0; prev_v[g] = 0; prev_hs[g] = 0;
      wait_c[g] = 0; clr_seen[g] = 0; rdcnt[g] = 0; mmcnt[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (clr_seen[g] != clr_cnt[g]) begin
          clr_seen[g] = clr_cnt[g];
          hs_prev[g] = 0; ready[g] = 1'b0; prev_v[g] = 0; prev_hs[g] = 0;
          wait_c[g] = new_delay(mode[g]);
        end
        if (mismatch[g]) mmcnt[g]++;
        if (busy[g]) begin
          checks++;
          if (rom_addr[g] >= 16'(num_of(g))) begin
            errors++;
            $display("FAIL rom_addr_range inst=%0d actual=%0d required<%0d", g, rom_addr[g], num_of(g));
          end
        end
        if (prev_v[g] && !prev_hs[g]) begin
          checks++;
          if (!valid[g] || addr[g] != prev_a[g] || wr[g] != prev_d[g] || rw[g] != prev_rw[g]) begin
            errors++;
            $display("FAIL stall_hold inst=%0d actual v=%0b a=%0h rw=%0b required v=1 a=%0h rw=%0b",
                     g, valid[g], addr[g], rw[g], prev_a[g], prev_rw[g]);
          end
        end
        if (hs_prev[g]) begin
          hs_prev[g] = 0; ready[g] = 1'b0; wait_c[g] = new_delay(mode[g]);
        end
        if (valid[g]) begin
          if (!ready[g]) begin
            if (wait_c[g] == 0) begin
              ready[g] = 1'b1;
              key = {4'(g), addr[g]};
              rd[g] = mem.exists(key) ? mem[key] : '0;
              if (rdcnt[g] - rd_base[g] == corrupt[g]) rd[g][0] = ~rd[g][0];
            end else begin
              wait_c[g]--;
            end
          end
        end else begin
          ready[g] = spur[g] ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        hs = valid[g] && ready[g];
        if (hs) begin
          hs_prev[g] = 1;
          if (exp_q[g].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cmd inst=%0d actual rw=%0b a=%0h required none", g, rw[g], addr[g]);
          end else begin
            e = exp_q[g].pop_front();
            checks++;
            if (e.rw != rw[g] || e.a != addr[g] || (e.rw && e.d != wr[g])) begin
              errors++;
              $display("FAIL cmd inst=%0d actual rw=%0b a=%0h d=%0h required rw=%0b a=%0h d=%0h",
                       g, rw[g], addr[g], wr[g], e.rw, e.a, e.d);
            end
          end
          if (rw[g]) begin
            mem[{4'(g), addr[g]}] = wr[g];
            wlog[g].push_back(wr[g]);
            alog[g].push_back(addr[g]);
          end else begin
            rdcnt[g]++;
          end
        end
        prev_v[g] = valid[g]; prev_hs[g] = hs; prev_a[g] = addr[g];
        prev_d[g] = wr[g]; prev_rw[g] = rw[g];
      end
    end
  end

  task automatic push_run(int g);
    for (int k = 0; k < num_of(g); k++) begin
      logic [27:0] a;
      a = base_of(g) + 28'(k * 8);
      exp_q[g].push_back('{rw: 1'b1, a: a, d: expand(rom_base[g] + 64'(k))});
      if (verify_of(g)) exp_q[g].push_back('{rw: 1'b0, a: a, d: '0});
    end
  endtask

  task automatic start_run(int g);
    wlog[g].delete();
    alog[g].delete();
    rd_base[g] = rdcnt[g];
    clr_cnt[g]++;
    push_run(g);
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
    chk("start_busy", g, 256'(busy[g]), 256'(1));
    chk("start_done_clr", g, 256'(done[g]), 256'(0));
  endtask

  task automatic wait_done(int g, int exp_err, int exp_mm);
    int mm0;
    bit got;
    mm0 = mmcnt[g];
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (done[g]) got = 1;
    end
    chk("done_seen", g, 256'(got), 256'(1));
    chk("all_cmds", g, 256'(exp_q[g].size()), 256'(0));
    chk("end_busy", g, 256'(busy[g]), 256'(0));
    chk("end_valid", g, 256'(valid[g]), 256'(0));
    chk("end_rw", g, 256'(rw[g]), 256'(1));
    chk("end_rom_addr", g, 256'(rom_addr[g]), 256'(num_of(g) - 1));
    chk("err_cnt", g, 256'(err_cnt[g]), 256'(exp_err));
    chk("mismatch_pulses", g, 256'(mmcnt[g] - mm0), 256'(exp_mm));
    chk("write_count", g, 256'(wlog[g].size()), 256'(num_of(g)));
  endtask

  task automatic chk_reset_vals(int g);
    chk("rst_valid", g, 256'(valid[g]), 256'(0));
    chk("rst_busy", g, 256'(busy[g]), 256'(0));
    chk("rst_done", g, 256'(done[g]), 256'(0));
    chk("rst_addr", g, 256'(addr[g]), 256'(base_of(g)));
    chk("rst_rw", g, 256'(rw[g]), 256'(1));
    chk("rst_rom_addr", g, 256'(rom_addr[g]), 256'(0));
    chk("rst_err", g, 256'(err_cnt[g]), 256'(0));
    chk("rst_wdata", g, wr[g], 256'(0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    bit found;
    for (int g = 0; g < NI; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; mode[g] = 0; spur[g] = 0;
      corrupt[g] = -1; rd_base[g] = 0; clr_cnt[g] = 0; rom_base[g] = 64'h0102030405060708;
    end
    #1;
    for (int g = 0; g < NI; g++) chk_reset_vals(g);
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) rst[g] = 1'b0;
    repeat (2) @(negedge clk);

    // Write-only path with fixed ROM pattern and one-cycle ready delay.
    start_run(0);
    wait_done(0, 0, 0);
    chk("first_data", 0, wlog[0][0],
        256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
    chk("addr0", 0, 256'(alog[0][0]), 256'(28'h3000000));
    chk("addr1", 0, 256'(alog[0][1]), 256'(28'h3000008));
    chk("addr2", 0, 256'(alog[0][2]), 256'(28'h3000010));
    chk("addr3", 0, 256'(alog[0][3]), 256'(28'h3000018));

    // Random stalls, spurious ready while idle, and a start pulse mid-run.
    for (int r = 0; r < 3; r++) begin
      mode[0] = 1; spur[0] = 1;
      rom_base[0] = {$urandom, $urandom};
      start_run(0);
      repeat (4 + r * 3) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      wait_done(0, 0, 0);
    end

    // Reset while word 1 is waiting for write acceptance.
    mode[0] = 0; spur[0] = 0;
    rom_base[0] = {$urandom, $urandom};
    start_run(0);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (valid[0] && rw[0] && rom_addr[0] == 16'd1) found = 1;
    end
    chk("reach_word1_wr", 0, 256'(found), 256'(1));
    rst[0] = 1'b1;
    #1;
    chk_reset_vals(0);
    exp_q[0].delete();
    clr_cnt[0]++;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle_valid", 0, 256'(valid[0]), 256'(0));
    chk("post_rst_idle_busy", 0, 256'(busy[0]), 256'(0));
    start_run(0);
    wait_done(0, 0, 0);
    chk("rerun_addr0", 0, 256'(alog[0][0]), 256'(28'h3000000));
    chk("rerun_data0", 0, wlog[0][0], expand(rom_base[0]));

    // Verify mode: clean echo, then a corrupted read-back of word 2, then clean again.
    mode[1] = 1; spur[1] = 1;
    rom_base[1] = {$urandom, $urandom};
    start_run(1);
    wait_done(1, 0, 0);
    rom_base[1] = {$urandom, $urandom};
    corrupt[1] = 2;
    start_run(1);
    wait_done(1, 1, 1);
    corrupt[1] = -1;
    mode[1] = 2;
    start_run(1);
    wait_done(1, 0, 0);

    // Address wrap at the top of the 28-bit space.
    mode[2] = 1;
    rom_base[2] = {$urandom, $urandom};
    start_run(2);
    wait_done(2, 0, 0);
    chk("wrap_addr0", 2, 256'(alog[2][0]), 256'(28'hFFFFFF8));
    chk("wrap_addr1", 2, 256'(alog[2][1]), 256'(28'h0000000));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
